// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load lane extraction, misalign suppression,
// stall/flush handling and a retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ld_en,
  input  logic [1:0]        mem_ld_size,
  input  logic              mem_ld_signed,
  input  logic [1:0]        mem_ld_off,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_valid,
  output logic              wb_misalign,
  output logic [31:0]       retire_cnt
);

  logic [ADDR_W-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              whilo_q, whilo_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic [31:0]       retire_q, retire_d;

  logic [31:0]       word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              misalign;
  logic [DATA_W-1:0] ld_data;
  logic              unused_stall;

  assign unused_stall = ^stall[3:0];
  assign word = mem_wdata[31:0];

  // Big-endian lanes: offset 0 is the most significant byte/halfword.
  always_comb begin
    case (mem_ld_off)
      2'd0:    ld_byte = word[31:24];
      2'd1:    ld_byte = word[23:16];
      2'd2:    ld_byte = word[15:8];
      default: ld_byte = word[7:0];
    endcase
    ld_half = mem_ld_off[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    misalign = 1'b0;
    ld_data  = mem_wdata;
    if (mem_ld_en) begin
      case (mem_ld_size)
        2'b00: ld_data = {{(DATA_W-8){mem_ld_signed & ld_byte[7]}}, ld_byte};
        2'b01: begin
          ld_data  = {{(DATA_W-16){mem_ld_signed & ld_half[15]}}, ld_half};
          misalign = mem_ld_off[0];
        end
        2'b10:   misalign = (mem_ld_off != 2'b00);
        default: misalign = 1'b1;
      endcase
    end
  end

  always_comb begin
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    whilo_d  = whilo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    valid_d  = valid_q;
    mis_d    = mis_q;
    retire_d = retire_q;
    if (rst || flush || (stall[4] && !stall[5])) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      whilo_d = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
      valid_d = 1'b0;
      mis_d   = 1'b0;
      if (rst) retire_d = '0;
    end else if (!stall[4]) begin
      wd_d     = mem_wd;
      valid_d  = mem_valid;
      whilo_d  = mem_whilo;
      hi_d     = mem_hi;
      lo_d     = mem_lo;
      mis_d    = misalign;
      wreg_d   = !misalign && mem_wreg && mem_valid && (mem_wd != '0);
      wdata_d  = misalign ? '0 : ld_data;
      if (mem_valid && !misalign) retire_d = retire_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    wd_q     <= wd_d;
    wreg_q   <= wreg_d;
    wdata_q  <= wdata_d;
    whilo_q  <= whilo_d;
    hi_q     <= hi_d;
    lo_q     <= lo_d;
    valid_q  <= valid_d;
    mis_q    <= mis_d;
    retire_q <= retire_d;
  end

  assign wb_wd       = wd_q;
  assign wb_wreg     = wreg_q;
  assign wb_wdata    = wdata_q;
  assign wb_whilo    = whilo_q;
  assign wb_hi       = hi_q;
  assign wb_lo       = lo_q;
  assign wb_valid    = valid_q;
  assign wb_misalign = mis_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Table-driven bench for mem_wb_stage with a scoreboard queue of expected
// WB outputs, plus a hand sequence for counter wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_ld_en;
  logic [1:0]  mem_ld_size;
  logic        mem_ld_signed;
  logic [1:0]  mem_ld_off;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi, wb_lo;
  logic        wb_valid, wb_misalign;
  logic [31:0] retire_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_ld_en(mem_ld_en), .mem_ld_size(mem_ld_size),
    .mem_ld_signed(mem_ld_signed), .mem_ld_off(mem_ld_off),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_valid(wb_valid), .wb_misalign(wb_misalign), .retire_cnt(retire_cnt)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        ld_en;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_valid;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic [5:0] st,
      input logic fl, input logic v, input logic [4:0] wd, input logic wr,
      input logic [31:0] d, input logic ld, input logic [1:0] sz, input logic sg,
      input logic [1:0] of, input logic hl, input logic [31:0] hi, input logic [31:0] lo,
      input logic [4:0] ewd, input logic ewr, input logic [31:0] ed, input logic ehl,
      input logic [31:0] ehi, input logic [31:0] elo, input logic ev, input logic em,
      input logic [31:0] ec);
    vec_t t;
    t.name = n; t.rst = r; t.stall = st; t.flush = fl; t.valid = v; t.wd = wd;
    t.wreg = wr; t.wdata = d; t.ld_en = ld; t.size = sz; t.sgn = sg; t.off = of;
    t.whilo = hl; t.hi = hi; t.lo = lo;
    t.e_wd = ewd; t.e_wreg = ewr; t.e_wdata = ed; t.e_whilo = ehl; t.e_hi = ehi;
    t.e_lo = elo; t.e_valid = ev; t.e_mis = em; t.e_cnt = ec;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; stall = t.stall; flush = t.flush; mem_valid = t.valid;
    mem_wd = t.wd; mem_wreg = t.wreg; mem_wdata = t.wdata; mem_ld_en = t.ld_en;
    mem_ld_size = t.size; mem_ld_signed = t.sgn; mem_ld_off = t.off;
    mem_whilo = t.whilo; mem_hi = t.hi; mem_lo = t.lo;
  endtask

  task automatic compare(input vec_t e);
    chk({e.name, ".wd"},      32'(wb_wd),       32'(e.e_wd));
    chk({e.name, ".wreg"},    32'(wb_wreg),     32'(e.e_wreg));
    chk({e.name, ".wdata"},   wb_wdata,         e.e_wdata);
    chk({e.name, ".whilo"},   32'(wb_whilo),    32'(e.e_whilo));
    chk({e.name, ".hi"},      wb_hi,            e.e_hi);
    chk({e.name, ".lo"},      wb_lo,            e.e_lo);
    chk({e.name, ".valid"},   32'(wb_valid),    32'(e.e_valid));
    chk({e.name, ".misalign"},32'(wb_misalign), 32'(e.e_mis));
    chk({e.name, ".retire"},  retire_cnt,       e.e_cnt);
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    drive(t);
    sb.push_back(t);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: empty queue at %s", t.name);
    end else compare(sb.pop_front());
  endtask

  localparam logic [5:0] RUN = 6'b000000, BUB = 6'b011111, HOLD = 6'b111111;

  initial begin
    // name rst stall flush valid wd wreg wdata ld size sgn off whilo hi lo | expected
    vecs.push_back(mk("reset",   1, RUN, 0, 1, 5'd9, 1, 32'h9999_9999, 0, 2'd2, 0, 2'd0, 1, 32'h1, 32'h2,
                      0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("alu_wb",  0, RUN, 0, 1, 5'd5, 1, 32'h1234_5678, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd5, 1, 32'h1234_5678, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("lb_s",    0, RUN, 0, 1, 5'd3, 1, 32'h11F2_3344, 1, 2'd0, 1, 2'd1, 0, 0, 0,
                      5'd3, 1, 32'hFFFF_FFF2, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk("lb_u",    0, RUN, 0, 1, 5'd3, 1, 32'h11F2_3344, 1, 2'd0, 0, 2'd1, 0, 0, 0,
                      5'd3, 1, 32'h0000_00F2, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk("lh_off2", 0, RUN, 0, 1, 5'd4, 1, 32'hAABB_8001, 1, 2'd1, 1, 2'd2, 0, 0, 0,
                      5'd4, 1, 32'hFFFF_8001, 0, 0, 0, 1, 0, 4));
    vecs.push_back(mk("lh_mis",  0, RUN, 0, 1, 5'd4, 1, 32'hAABB_8001, 1, 2'd1, 1, 2'd1, 0, 0, 0,
                      5'd4, 0, 32'h0, 0, 0, 0, 1, 1, 4));
    vecs.push_back(mk("lb_off0", 0, RUN, 0, 1, 5'd6, 1, 32'h80FF_0000, 1, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd6, 1, 32'h0000_0080, 0, 0, 0, 1, 0, 5));
    vecs.push_back(mk("lb_off3", 0, RUN, 0, 1, 5'd6, 1, 32'h0000_0080, 1, 2'd0, 1, 2'd3, 0, 0, 0,
                      5'd6, 1, 32'hFFFF_FF80, 0, 0, 0, 1, 0, 6));
    vecs.push_back(mk("lh_off0", 0, RUN, 0, 1, 5'd8, 1, 32'hAABB_8001, 1, 2'd1, 1, 2'd0, 0, 0, 0,
                      5'd8, 1, 32'hFFFF_AABB, 0, 0, 0, 1, 0, 7));
    vecs.push_back(mk("lw_hilo", 0, RUN, 0, 1, 5'd7, 1, 32'hDEAD_BEEF, 1, 2'd2, 1, 2'd0, 1, 32'h1111, 32'h2222,
                      5'd7, 1, 32'hDEAD_BEEF, 1, 32'h1111, 32'h2222, 1, 0, 8));
    vecs.push_back(mk("lw_mis",  0, RUN, 0, 1, 5'd7, 1, 32'hDEAD_BEEF, 1, 2'd2, 0, 2'd2, 0, 0, 0,
                      5'd7, 0, 32'h0, 0, 0, 0, 1, 1, 8));
    vecs.push_back(mk("sz11",    0, RUN, 0, 1, 5'd7, 1, 32'hDEAD_BEEF, 1, 2'd3, 0, 2'd0, 0, 0, 0,
                      5'd7, 0, 32'h0, 0, 0, 0, 1, 1, 8));
    vecs.push_back(mk("r0_wr",   0, RUN, 0, 1, 5'd0, 1, 32'h0000_0055, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd0, 0, 32'h0000_0055, 0, 0, 0, 1, 0, 9));
    vecs.push_back(mk("invalid", 0, RUN, 0, 0, 5'd9, 1, 32'h0000_0099, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd9, 0, 32'h0000_0099, 0, 0, 0, 0, 0, 9));
    vecs.push_back(mk("bubble",  0, BUB, 0, 1, 5'd9, 1, 32'h0000_0099, 0, 2'd0, 0, 2'd0, 1, 32'h5, 32'h6,
                      0, 0, 0, 0, 0, 0, 0, 0, 9));
    vecs.push_back(mk("cap_a",   0, RUN, 0, 1, 5'd10, 1, 32'h0000_000A, 0, 2'd0, 0, 2'd0, 1, 32'h3, 32'h4,
                      5'd10, 1, 32'h0000_000A, 1, 32'h3, 32'h4, 1, 0, 10));
    vecs.push_back(mk("hold1",   0, HOLD, 0, 1, 5'd11, 1, 32'h0000_000B, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd10, 1, 32'h0000_000A, 1, 32'h3, 32'h4, 1, 0, 10));
    vecs.push_back(mk("hold2",   0, HOLD, 0, 1, 5'd11, 1, 32'h0000_000B, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd10, 1, 32'h0000_000A, 1, 32'h3, 32'h4, 1, 0, 10));
    vecs.push_back(mk("release", 0, RUN, 0, 1, 5'd11, 1, 32'h0000_000B, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd11, 1, 32'h0000_000B, 0, 0, 0, 1, 0, 11));
    vecs.push_back(mk("flush_st",0, HOLD, 1, 1, 5'd12, 1, 32'h1234_5678, 1, 2'd2, 0, 2'd0, 1, 32'h7, 32'h8,
                      0, 0, 0, 0, 0, 0, 0, 0, 11));
    vecs.push_back(mk("cap_c",   0, RUN, 0, 1, 5'd12, 1, 32'h0000_000C, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd12, 1, 32'h0000_000C, 0, 0, 0, 1, 0, 12));
    vecs.push_back(mk("hold_c",  0, HOLD, 0, 1, 5'd13, 1, 32'h0000_000D, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd12, 1, 32'h0000_000C, 0, 0, 0, 1, 0, 12));
    vecs.push_back(mk("rst_hold",1, HOLD, 0, 1, 5'd13, 1, 32'h0000_000D, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("post_rst",0, RUN, 0, 1, 5'd13, 1, 32'h0000_000D, 0, 2'd0, 0, 2'd0, 0, 0, 0,
                      5'd13, 1, 32'h0000_000D, 0, 0, 0, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Counter wrap: preload 0xFFFFFFFF through the next-state net during a hold.
    @(negedge clk);
    stall = HOLD; flush = 1'b0; rst = 1'b0;
    force dut.retire_d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("preload.retire", retire_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    release dut.retire_d;
    step(mk("wrap", 0, RUN, 0, 1, 5'd14, 1, 32'h0000_000E, 0, 2'd0, 0, 2'd0, 0, 0, 0,
            5'd14, 1, 32'h0000_000E, 0, 0, 0, 1, 0, 0));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
